// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter must hold values 0..WIDTH inclusive.
    function automatic int SERIAL_SUB_CNT_W(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/fs_gate.sv
// Gate-level full subtractor cell: diff = a ^ b ^ bin, bout = ~a&b | ~(a^b)&bin.
module fs_gate (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic a_x_b;
    logic a_n;
    logic a_x_b_n;
    logic brw_gen;
    logic brw_prop;

    xor g_x0 (a_x_b, a, b);
    xor g_x1 (diff, a_x_b, bin);
    not g_n0 (a_n, a);
    not g_n1 (a_x_b_n, a_x_b);
    and g_a0 (brw_gen, a_n, b);
    and g_a1 (brw_prop, a_x_b_n, bin);
    or  g_o0 (bout, brw_gen, brw_prop);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first, WIDTH cycles per result.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CNT_W = SERIAL_SUB_CNT_W(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic [CNT_W-1:0]   cnt;
    logic               br;
    logic               d_bit;
    logic               br_next;
    logic               last_bit;

    fs_gate u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .diff (d_bit),
        .bout (br_next)
    );

    assign last_bit = (cnt == LAST_BIT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, serial shift, borrow chain and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    res_sr <= {d_bit, res_sr[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= br_next;
                    cnt    <= cnt + CNT_W'(1);
                    // Outputs are loaded only on the final bit so they hold across later RUNs.
                    if (last_bit) begin
                        diff <= {d_bit, res_sr[WIDTH-1:1]};
                        bout <= br_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: driver pushes expected results, monitor pops on done.
module tb_serial_sub;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         b;
        int           cyc;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_in),
        .b     (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_diff"}, int'(diff), int'(e.d));
                chk({e.name, "_bout"}, int'(bout), int'(e.b));
                chk({e.name, "_done_cycle"}, cyc, e.cyc);
            end
        end
    end

    task automatic issue(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] ed, input logic eb);
        exp_t e;
        @(negedge clk);
        a_in  = av;
        b_in  = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.d = ed; e.b = eb; e.cyc = cyc + W; e.name = name;
        q.push_back(e);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy && !done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_bout", int'(bout), 0);
        rst = 1'b0;

        // Basic subtract with busy profile.
        issue("basic", 8'd200, 8'd55, 8'd145, 1'b0);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("basic_busy", int'(busy), 1);
        end
        wait_idle();

        issue("borrow", 8'd5, 8'd10, 8'd251, 1'b1);   wait_idle();
        issue("zero", 8'd0, 8'd0, 8'd0, 1'b0);        wait_idle();
        issue("max", 8'd255, 8'd255, 8'd0, 1'b0);     wait_idle();
        issue("wrap", 8'd0, 8'd1, 8'd255, 1'b1);      wait_idle();

        // Start during RUN cycle 3 must be ignored.
        issue("busy_start", 8'd200, 8'd55, 8'd145, 1'b0);
        repeat (2) @(negedge clk);
        a_in = 8'd1; b_in = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset at RUN cycle 4 abandons the operation.
        issue("aborted", 8'd200, 8'd55, 8'd145, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_diff", int'(diff), 0);
        chk("midrst_bout", int'(bout), 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        issue("after_rst", 8'd100, 8'd1, 8'd99, 1'b0);
        wait_idle();

        // Back-to-back: start held high through DONE.
        issue("b2b_first", 8'd50, 8'd20, 8'd30, 1'b0);
        @(negedge clk);
        a_in = 8'd17; b_in = 8'd3; start = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (done) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!seen) chk("b2b_done_timeout", 0, 1);
        end
        begin
            exp_t e;
            @(posedge clk);
            #1;
            e.d = 8'd14; e.b = 1'b0; e.cyc = cyc + W; e.name = "b2b_second";
            q.push_back(e);
            start = 1'b0;
        end
        wait_idle();

        // Random sweep against an arithmetic reference.
        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic [W-1:0] rd;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rd = ra - rb;
            issue("rand", ra, rb, rd, ra < rb);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial unsigned subtractor; the borrow-chain counterpart of the team's gate-level full-adder cell.
- Computes diff = a − b over WIDTH clock cycles, LSB first, using a single full-subtractor cell and a registered borrow.
- Sits in the arithmetic datapath where area matters more than latency.
- Uses a start/busy/done handshake toward its controller.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range is 2 or more.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request pulse; sampled only when not busy.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse; diff and bout are valid from this cycle on.
- diff  output  WIDTH  difference, (a − b) mod 2^WIDTH.
- bout  output  1  final borrow; 1 exactly when a < b (unsigned).

Behaviour:
- Reset (rst high at an edge) forces: state=IDLE, busy=0, done=0, diff=0, bout=0, borrow register=0, bit counter=0. Reset overrides all other inputs.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge E0 captures a and b into shift registers, clears the borrow register and counter, and moves to RUN. busy=1 from E0 onward.
  - RUN: at each edge E1..EWIDTH, take the LSBs of the operand registers and the current borrow.
    - d = a0 ^ b0 ^ br
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
    - Shift d into the MSB of the result register; shift both operand registers right; counter increments.
  - RUN exit: at edge EWIDTH (counter reaches WIDTH−1 → WIDTH), state becomes DONE. busy=0, done=1, diff = full result, bout = br_next from the final bit.
  - DONE: lasts exactly one cycle. At the next edge the state returns to IDLE and done=0. If start=1 at that edge, the block goes straight to RUN with new operands, so back-to-back operation is legal.
- Latency: done is high in the cycle following edge E0+WIDTH. Throughput is one result per WIDTH+1 cycles.
- start while busy: ignored; the operand registers are not disturbed.
- a and b may change freely after E0.
- diff and bout hold their last values until the next accepted start's DONE or a reset.
- During RUN, diff is a partial value and is not guaranteed meaningful.
- Reset mid-RUN: the operation is abandoned, all outputs go to their reset values, and no done pulse is produced.
- Width rules: the counter is clog2(WIDTH+1) bits. There is no internal sign handling; bout is the only overflow indication.

Decomposition:
- Shared arithmetic package:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - SERIAL_SUB_CNT_W function/constant = clog2(WIDTH+1)
- One natural sub-module, fs_gate: gate-level full subtractor.
  - Ports a, b, bin → diff, bout.
  - Built from xor/and/or/not primitives.
  - Instantiated once in the datapath.
- Everything else (FSM, counter, shift registers) stays in serial_sub.

Test Plan:
- Basic subtract: WIDTH=8, a=200, b=55, start 1 cycle → busy for 8 cycles, done pulse in cycle 9, diff=145, bout=0.
- Borrow out: a=5, b=10 → diff=251, bout=1.
- Extremes:
  - a=0, b=0 → diff=0, bout=0.
  - a=255, b=255 → diff=0, bout=0.
  - a=0, b=1 → diff=255, bout=1.
- Start while busy: start pulsed at RUN cycle 3 with a=1, b=1 → ignored; the original result (200−55=145) is still produced with done at the same cycle.
- Reset mid-operation: rst asserted at RUN cycle 4 → next cycle busy=0, done=0, diff=0, bout=0; no done pulse follows. A subsequent start with a=100, b=1 yields 99.
- Back-to-back: start held high through DONE with a=17, b=3 → done for the first result, then immediate RUN, next done exactly 9 cycles later with diff=14. Plus a randomized sweep of 1000 operand pairs against a reference model.
